// File: rtl/key_extract_param.sv
// Key extractor for one RMT stage. It builds the match key from PHV containers selected per
// table entry, adds a 1-bit comparator condition, and loads its tables over the control stream.

module key_extract_sel #(
    parameter int N     = 8,
    parameter int W     = 16,
    parameter int SEL_W = 3
) (
    input  logic [N-1:0][W-1:0] cont,
    input  logic [SEL_W-1:0]    sel,
    output logic [W-1:0]        val
);
    always_comb begin
        val = '0;
        if (int'(sel) < N) val = cont[sel];
    end
endmodule

module key_extract_param #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int STAGE_ID             = 0,
    parameter int KEY_EX_ID            = 1,
    parameter int CONT_NUM             = 8,
    parameter int KEY_OFF_ADDR_WIDTH   = 5,
    parameter int META_LEN             = 356,
    parameter int IDX_LSB              = 129,
    localparam int SEL_W   = $clog2(CONT_NUM),
    localparam int PHV_LEN = CONT_NUM*(48+32+16)+META_LEN,
    localparam int KEY_LEN = 2*48+2*32+2*16+1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic                              phv_valid_in,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_valid_out,
    output logic [KEY_LEN-1:0]                key_out,
    output logic                              key_valid_out,
    output logic [KEY_LEN-1:0]                key_mask_out,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast
);
    localparam int OFF_W  = 6*SEL_W + 20;
    localparam int DEPTH  = 2**KEY_OFF_ADDR_WIDTH;
    localparam int STAGES = 3;
    localparam logic [7:0] MOD_ID = {3'(KEY_EX_ID), 5'(STAGE_ID)};

    logic [OFF_W-1:0]   off_tbl  [DEPTH];
    logic [KEY_LEN-1:0] mask_tbl [DEPTH];

    // ---------------- PHV / key pipeline ----------------
    logic [STAGES-1:0]             vld_pipe;
    logic [PHV_LEN-1:0]            phv_s1, phv_s2;
    logic [OFF_W-1:0]              off_s1;
    logic [KEY_LEN-1:0]            mask_s1, mask_s2, key_s2;
    logic [KEY_OFF_ADDR_WIDTH-1:0] idx;

    logic [CONT_NUM-1:0][47:0] c6;
    logic [CONT_NUM-1:0][31:0] c4;
    logic [CONT_NUM-1:0][15:0] c2;
    logic [1:0][47:0]          f6;
    logic [1:0][31:0]          f4;
    logic [1:0][15:0]          f2;
    logic [1:0][15:0]          opv;
    logic                      cond;

    assign idx = phv_in[IDX_LSB +: KEY_OFF_ADDR_WIDTH];
    assign c2  = phv_s1[META_LEN +: CONT_NUM*16];
    assign c4  = phv_s1[META_LEN + CONT_NUM*16 +: CONT_NUM*32];
    assign c6  = phv_s1[META_LEN + CONT_NUM*48 +: CONT_NUM*48];

    // index 0 is the "b" field / operand B, index 1 the "a" field / operand A
    for (genvar g = 0; g < 2; g++) begin : g_sel
        logic [8:0]  opnd;
        logic [15:0] opc;
        key_extract_sel #(.N(CONT_NUM), .W(48), .SEL_W(SEL_W)) u_sel6 (
            .cont(c6), .sel(off_s1[20+(4+g)*SEL_W +: SEL_W]), .val(f6[g]));
        key_extract_sel #(.N(CONT_NUM), .W(32), .SEL_W(SEL_W)) u_sel4 (
            .cont(c4), .sel(off_s1[20+(2+g)*SEL_W +: SEL_W]), .val(f4[g]));
        key_extract_sel #(.N(CONT_NUM), .W(16), .SEL_W(SEL_W)) u_sel2 (
            .cont(c2), .sel(off_s1[20+g*SEL_W +: SEL_W]), .val(f2[g]));
        assign opnd = off_s1[g*9 +: 9];
        key_extract_sel #(.N(CONT_NUM), .W(16), .SEL_W(SEL_W)) u_selop (
            .cont(c2), .sel(opnd[SEL_W-1:0]), .val(opc));
        assign opv[g] = opnd[8] ? {8'h00, opnd[7:0]} : opc;
    end

    always_comb begin
        cond = 1'b1;
        case (off_s1[19:18])
            2'b01:   cond = opv[1] >  opv[0];
            2'b10:   cond = opv[1] >= opv[0];
            2'b11:   cond = opv[1] == opv[0];
            default: cond = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe     <= '0;
            phv_s1       <= '0;
            off_s1       <= '0;
            mask_s1      <= '0;
            phv_s2       <= '0;
            mask_s2      <= '0;
            key_s2       <= '0;
            phv_out      <= '0;
            key_out      <= '0;
            key_mask_out <= '0;
        end else begin
            vld_pipe     <= {vld_pipe[STAGES-2:0], phv_valid_in};
            phv_s1       <= phv_in;
            off_s1       <= off_tbl[idx];
            mask_s1      <= mask_tbl[idx];
            phv_s2       <= phv_s1;
            mask_s2      <= mask_s1;
            key_s2       <= {f6[1], f6[0], f4[1], f4[0], f2[1], f2[0], cond};
            phv_out      <= phv_s2;
            key_out      <= key_s2;
            key_mask_out <= mask_s2;
        end
    end

    assign phv_valid_out = vld_pipe[STAGES-1];
    assign key_valid_out = vld_pipe[STAGES-1];

    // ---------------- control path ----------------
    typedef enum logic [1:0] {IDLE, WRITE, FWD, DROP} state_t;
    state_t     state, state_nxt;
    logic [3:0] res_q;
    logic       fwd, wr_off, wr_mask, res_ld;
    logic [7:0] hdr_id;
    logic [3:0] hdr_res;
    logic [KEY_OFF_ADDR_WIDTH-1:0] wr_idx;

    assign hdr_id  = c_s_axis_tdata[375:368];
    assign hdr_res = c_s_axis_tdata[383:380];
    assign wr_idx  = c_s_axis_tdata[C_S_AXIS_DATA_WIDTH-8 +: KEY_OFF_ADDR_WIDTH];

    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        wr_off    = 1'b0;
        wr_mask   = 1'b0;
        res_ld    = 1'b0;
        case (state)
            IDLE: if (c_s_axis_tvalid) begin
                if (hdr_id == MOD_ID) begin
                    res_ld = 1'b1;
                    if (!c_s_axis_tlast) state_nxt = WRITE;
                end else begin
                    fwd = 1'b1;
                    if (!c_s_axis_tlast) state_nxt = FWD;
                end
            end
            WRITE: if (c_s_axis_tvalid) begin
                wr_off    = (res_q == 4'd0);
                wr_mask   = (res_q == 4'd1);
                state_nxt = c_s_axis_tlast ? IDLE : DROP;
            end
            FWD: if (c_s_axis_tvalid) begin
                fwd = 1'b1;
                if (c_s_axis_tlast) state_nxt = IDLE;
            end
            DROP: if (c_s_axis_tvalid && c_s_axis_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            res_q           <= '0;
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end else begin
            state           <= state_nxt;
            c_m_axis_tvalid <= fwd;
            if (res_ld) res_q <= hdr_res;
            if (fwd) begin
                c_m_axis_tdata <= c_s_axis_tdata;
                c_m_axis_tuser <= c_s_axis_tuser;
                c_m_axis_tkeep <= c_s_axis_tkeep;
                c_m_axis_tlast <= c_s_axis_tlast;
            end
        end
    end

    // Table storage has no reset; reads above see the pre-write entry.
    always_ff @(posedge clk) begin
        if (wr_off)  off_tbl[wr_idx]  <= c_s_axis_tdata[OFF_W-1:0];
        if (wr_mask) mask_tbl[wr_idx] <= c_s_axis_tdata[KEY_LEN-1:0];
    end
endmodule

// File: tb/tb_key_extract_param.sv
// Bench for key_extract_param: vector table plus hand sequences, checked through
// key and control-forward scoreboards.

module tb_key_extract_param;
    localparam int DW = 512, UW = 128, N = 8, META = 356, IDXL = 129;
    localparam int PHV_LEN = N*96 + META;
    localparam int KEY_LEN = 193;
    localparam logic [7:0] MY_ID = 8'h20;

    logic clk = 1'b0, rst = 1'b1;
    logic [PHV_LEN-1:0] phv_in = '0, phv_out;
    logic phv_valid_in = 1'b0, phv_valid_out, key_valid_out;
    logic [KEY_LEN-1:0] key_out, key_mask_out;
    logic [DW-1:0] c_s_axis_tdata = '0, c_m_axis_tdata;
    logic [UW-1:0] c_s_axis_tuser = '0, c_m_axis_tuser;
    logic [DW/8-1:0] c_s_axis_tkeep = '0, c_m_axis_tkeep;
    logic c_s_axis_tvalid = 1'b0, c_s_axis_tlast = 1'b0, c_m_axis_tvalid, c_m_axis_tlast;

    key_extract_param dut (
        .clk(clk), .rst(rst), .phv_in(phv_in), .phv_valid_in(phv_valid_in),
        .phv_out(phv_out), .phv_valid_out(phv_valid_out), .key_out(key_out),
        .key_valid_out(key_valid_out), .key_mask_out(key_mask_out),
        .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tuser(c_s_axis_tuser),
        .c_s_axis_tkeep(c_s_axis_tkeep), .c_s_axis_tvalid(c_s_axis_tvalid),
        .c_s_axis_tlast(c_s_axis_tlast), .c_m_axis_tdata(c_m_axis_tdata),
        .c_m_axis_tuser(c_m_axis_tuser), .c_m_axis_tkeep(c_m_axis_tkeep),
        .c_m_axis_tvalid(c_m_axis_tvalid), .c_m_axis_tlast(c_m_axis_tlast));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [PHV_LEN-1:0] phv;
        logic [KEY_LEN-1:0] key;
        logic [KEY_LEN-1:0] mask;
        int t;
    } exp_t;
    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [DW/8-1:0] keep;
        logic last;
    } beat_t;
    typedef struct {
        logic [37:0] off;
        logic [15:0] c2_7;
        logic [KEY_LEN-1:0] key;
    } vec_t;

    exp_t  sb[$];
    beat_t fq[$];
    int total = 0, bad = 0;
    logic [37:0]        sh_off  [32];
    logic [KEY_LEN-1:0] sh_mask [32];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_off(input int s6a, s6b, s4a, s4b, s2a, s2b,
                                           input logic [1:0] op, input logic [8:0] a, b);
        return {3'(s6a), 3'(s6b), 3'(s4a), 3'(s4b), 3'(s2a), 3'(s2b), op, a, b};
    endfunction

    function automatic logic [PHV_LEN-1:0] mk_phv(input logic [4:0] idx, input logic [15:0] c2_7,
                                                  input logic [31:0] tag);
        logic [PHV_LEN-1:0] p = '0;
        for (int i = 0; i < N; i++) begin
            p[META + 48*N + 48*i +: 48] = (i == 7) ? {6{8'hff}} : (i == 6) ? {6{8'hee}} : {6{8'(i)}};
            p[META + 16*N + 32*i +: 32] = (i == 7) ? 32'hcccccccc : (i == 6) ? 32'hbbbbbbbb
                                                   : {4{8'(8'h40 + i)}};
            p[META + 16*i +: 16] = (i == 7) ? c2_7 : (i == 6) ? 16'heeee : {2{8'(8'h20 + i)}};
        end
        p[31:0] = tag;
        p[IDXL +: 5] = idx;
        return p;
    endfunction

    function automatic logic [15:0] model_op(input logic [PHV_LEN-1:0] p, input logic [8:0] o);
        return o[8] ? {8'h00, o[7:0]} : p[META + 16*int'(o[2:0]) +: 16];
    endfunction

    function automatic logic [KEY_LEN-1:0] key_model(input logic [PHV_LEN-1:0] p, input logic [37:0] o);
        logic [15:0] a = model_op(p, o[17:9]);
        logic [15:0] b = model_op(p, o[8:0]);
        logic c;
        case (o[19:18])
            2'b00: c = 1'b1;
            2'b01: c = a > b;
            2'b10: c = a >= b;
            default: c = a == b;
        endcase
        return {p[META + 48*N + 48*int'(o[37:35]) +: 48], p[META + 48*N + 48*int'(o[34:32]) +: 48],
                p[META + 16*N + 32*int'(o[31:29]) +: 32], p[META + 16*N + 32*int'(o[28:26]) +: 32],
                p[META + 16*int'(o[25:23]) +: 16], p[META + 16*int'(o[22:20]) +: 16], c};
    endfunction

    function automatic logic [DW-1:0] hdr(input logic [3:0] res, input logic [7:0] id);
        logic [DW-1:0] d = '0;
        d[383:380] = res;
        d[375:368] = id;
        d[100:0]   = 101'h1_dead_beef_cafe;
        return d;
    endfunction

    function automatic logic [DW-1:0] dbeat(input logic [7:0] idx, input logic [KEY_LEN-1:0] pl);
        logic [DW-1:0] d = '0;
        d[511:504] = idx;
        d[KEY_LEN-1:0] = pl;
        return d;
    endfunction

    task automatic beat(input logic [DW-1:0] d, input logic last, input logic exp_fwd);
        c_s_axis_tdata  = d;
        c_s_axis_tuser  = {4{d[31:0]}};
        c_s_axis_tkeep  = d[63:0];
        c_s_axis_tlast  = last;
        c_s_axis_tvalid = 1'b1;
        if (exp_fwd) fq.push_back('{d, {4{d[31:0]}}, d[63:0], last});
        tick();
        c_s_axis_tvalid = 1'b0;
    endtask

    task automatic write_entry(input logic [3:0] res, input logic [4:0] idx, input logic [KEY_LEN-1:0] pl);
        beat(hdr(res, MY_ID), 1'b0, 1'b0);
        beat(dbeat(8'(idx), pl), 1'b1, 1'b0);
        if (res == 4'd0) sh_off[idx] = pl[37:0];
        if (res == 4'd1) sh_mask[idx] = pl;
    endtask

    task automatic send_phv(input logic [PHV_LEN-1:0] p, input logic [KEY_LEN-1:0] k, input logic [KEY_LEN-1:0] m);
        phv_in = p;
        phv_valid_in = 1'b1;
        sb.push_back('{p, k, m, cyc});
        tick();
        phv_valid_in = 1'b0;
    endtask

    task automatic send_model(input logic [4:0] idx, input logic [15:0] c2_7, input logic [31:0] tag);
        logic [PHV_LEN-1:0] p = mk_phv(idx, c2_7, tag);
        send_phv(p, key_model(p, sh_off[idx]), sh_mask[idx]);
    endtask

    exp_t  me;
    beat_t mb;
    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid_out || phv_valid_out) begin
                chk("kv_eq_pv", DW'(key_valid_out), DW'(phv_valid_out));
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_key got=%0h exp=none", key_out);
                end else begin
                    me = sb.pop_front();
                    chk("key", DW'(key_out), DW'(me.key));
                    chk("mask", DW'(key_mask_out), DW'(me.mask));
                    chk("phv_match", DW'(phv_out == me.phv), DW'(1));
                    chk("latency", DW'(cyc - me.t), DW'(3));
                end
            end
            if (c_m_axis_tvalid) begin
                if (fq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_fwd got=%0h exp=none", c_m_axis_tdata);
                end else begin
                    mb = fq.pop_front();
                    chk("fwd_data", c_m_axis_tdata, mb.data);
                    chk("fwd_side", DW'({c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast}),
                        DW'({mb.user, mb.keep, mb.last}));
                end
            end
        end
    end

    vec_t vt[8];
    localparam logic [8:0] OPC7 = 9'h007, OPC6 = 9'h006, IMMFF = 9'h1ff, IMM5 = 9'h105;
    localparam logic [191:0] HI = {48'hffffffffffff, 48'heeeeeeeeeeee, 32'hcccccccc, 32'hbbbbbbbb};

    initial begin
        vt[0] = '{mk_off(7,6,7,6,7,6,2'b00,9'h0,9'h0), 16'hffff, {HI, 16'hffff, 16'heeee, 1'b1}};
        vt[1] = '{mk_off(7,6,7,6,7,6,2'b11,OPC7,IMMFF), 16'h00ff, {HI, 16'h00ff, 16'heeee, 1'b1}};
        vt[2] = '{mk_off(7,6,7,6,7,6,2'b11,OPC7,IMMFF), 16'h0100, {HI, 16'h0100, 16'heeee, 1'b0}};
        vt[3] = '{mk_off(7,6,7,6,7,6,2'b01,OPC7,IMMFF), 16'h0100, {HI, 16'h0100, 16'heeee, 1'b1}};
        vt[4] = '{mk_off(7,6,7,6,7,6,2'b10,OPC7,IMMFF), 16'h00ff, {HI, 16'h00ff, 16'heeee, 1'b1}};
        vt[5] = '{mk_off(7,6,7,6,7,6,2'b01,OPC7,IMMFF), 16'h00ff, {HI, 16'h00ff, 16'heeee, 1'b0}};
        vt[6] = '{mk_off(0,1,2,3,4,5,2'b11,IMM5,IMM5), 16'h1234,
                  {48'h0, 48'h010101010101, 32'h42424242, 32'h43434343, 16'h2424, 16'h2525, 1'b1}};
        vt[7] = '{mk_off(7,6,7,6,7,6,2'b01,OPC6,OPC7), 16'heeef, {HI, 16'heeef, 16'heeee, 1'b0}};

        repeat (2) tick();
        chk("rst_key_valid", DW'(key_valid_out), DW'(0));
        chk("rst_phv_valid", DW'(phv_valid_out), DW'(0));
        chk("rst_key", DW'(key_out), DW'(0));
        chk("rst_fwd_valid", DW'(c_m_axis_tvalid), DW'(0));
        rst = 1'b0;
        tick();

        // selection and comparator vectors on index 0
        write_entry(4'd1, 5'd0, '1);
        foreach (vt[i]) begin
            write_entry(4'd0, 5'd0, KEY_LEN'(vt[i].off));
            send_phv(mk_phv(5'd0, vt[i].c2_7, 32'(i)), vt[i].key, '1);
        end

        // foreign packet is forwarded verbatim and must not touch index 0
        beat(hdr(4'd0, 8'h22), 1'b0, 1'b1);
        beat(dbeat(8'd0, KEY_LEN'(mk_off(7,7,7,7,7,7,2'b00,9'h0,9'h0))), 1'b1, 1'b1);
        send_model(5'd0, 16'h1234, 32'h300);

        // back-to-back PHVs on distinct entries
        write_entry(4'd0, 5'd1, KEY_LEN'(mk_off(6,7,6,7,6,7,2'b11,OPC7,OPC6)));
        write_entry(4'd1, 5'd1, {1'b0, {12{16'ha5c3}}});
        send_model(5'd0, 16'heeee, 32'h400);
        send_model(5'd1, 16'heeee, 32'h401);
        send_model(5'd1, 16'h0001, 32'h402);

        // write and lookup of index 3 in the same cycle: lookup sees the old entry
        write_entry(4'd0, 5'd3, KEY_LEN'(mk_off(1,2,3,4,5,6,2'b00,9'h0,9'h0)));
        write_entry(4'd1, 5'd3, {KEY_LEN{1'b1}} >> 7);
        beat(hdr(4'd0, MY_ID), 1'b0, 1'b0);
        c_s_axis_tdata = dbeat(8'd3, KEY_LEN'(mk_off(5,4,3,2,1,0,2'b10,OPC6,OPC7)));
        c_s_axis_tlast = 1'b1;
        c_s_axis_tvalid = 1'b1;
        phv_in = mk_phv(5'd3, 16'h5555, 32'h500);
        phv_valid_in = 1'b1;
        sb.push_back('{phv_in, key_model(phv_in, sh_off[3]), sh_mask[3], cyc});
        tick();
        c_s_axis_tvalid = 1'b0;
        phv_valid_in = 1'b0;
        sh_off[3] = mk_off(5,4,3,2,1,0,2'b10,OPC6,OPC7);
        send_model(5'd3, 16'h5555, 32'h501);
        repeat (5) tick();

        // reset mid-write with two PHVs in flight
        write_entry(4'd0, 5'd5, KEY_LEN'(mk_off(2,2,2,2,2,2,2'b00,9'h0,9'h0)));
        write_entry(4'd1, 5'd5, 193'h1_0000_ffff);
        phv_in = mk_phv(5'd5, 16'h1, 32'h600);
        phv_valid_in = 1'b1;
        tick();
        phv_in = mk_phv(5'd5, 16'h2, 32'h601);
        c_s_axis_tdata = hdr(4'd0, MY_ID);
        c_s_axis_tlast = 1'b0;
        c_s_axis_tvalid = 1'b1;
        tick();
        phv_valid_in = 1'b0;
        c_s_axis_tdata = dbeat(8'd5, KEY_LEN'(mk_off(3,3,3,3,3,3,2'b00,9'h0,9'h0)));
        c_s_axis_tlast = 1'b1;
        rst = 1'b1;
        #2;
        chk("arst_key_valid", DW'(key_valid_out), DW'(0));
        chk("arst_phv_out", DW'(phv_out == '0), DW'(1));
        chk("arst_key_out", DW'(key_out), DW'(0));
        tick();
        rst = 1'b0;
        c_s_axis_tvalid = 1'b0;
        chk("post_rst_mask", DW'(key_mask_out), DW'(0));
        repeat (4) tick();
        send_model(5'd5, 16'h3, 32'h700);
        write_entry(4'd0, 5'd5, KEY_LEN'(mk_off(4,0,4,0,4,0,2'b11,OPC7,IMM5)));
        send_model(5'd5, 16'h0005, 32'h701);

        for (int i = 0; i < 20 && (sb.size() != 0 || fq.size() != 0); i++) tick();
        chk("drain_left", DW'(sb.size() + fq.size()), DW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
